// File: rtl/arb_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package arb_pkg;

    localparam int ARB_N = 4;

    typedef logic [ARB_N-1:0] req_vec_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: rotate the request vector so ptr sits at
// bit 0, take the lowest set bit, then rotate the one-hot result back.
module rr_pick4
    import arb_pkg::*;
(
    input  req_vec_t   req,
    input  logic [1:0] ptr,
    output req_vec_t   pick,
    output logic [1:0] idx
);

    logic [7:0] dbl;
    logic [7:0] dbl_back;
    req_vec_t   rot;
    req_vec_t   rpick;
    logic [1:0] idx_r;

    // Rotate, fixed-priority select on the rotated vector, rotate back.
    always_comb begin
        dbl = {req, req};
        rot = dbl[{1'b0, ptr} +: 4];
        casez (rot)
            4'b???1: begin rpick = 4'b0001; idx_r = 2'd0; end
            4'b??10: begin rpick = 4'b0010; idx_r = 2'd1; end
            4'b?100: begin rpick = 4'b0100; idx_r = 2'd2; end
            4'b1000: begin rpick = 4'b1000; idx_r = 2'd3; end
            default: begin rpick = 4'b0000; idx_r = 2'd0; end
        endcase
        dbl_back = {rpick, rpick} << ptr;
        pick     = dbl_back[7:4];
        idx      = idx_r + ptr;
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a registered one-hot grant that
// feeds a 4-to-2 encoder. A grant is held until done or until the owner
// drops its request, and at least one idle cycle separates grants.
// Optional feature: define ARB_TIMEOUT_EN to bound each grant to
// TIMEOUT_CYCLES cycles, with a one-cycle timeout_err pulse on revocation.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic     clk,
    input  logic     rst,
    input  req_vec_t req,
    input  logic     done,
    output req_vec_t gnt,
    output logic     gnt_valid,
    output logic     timeout_err
);

    // The encoder downstream is exactly four wide; reject other sizes early.
    if (N_REQ != ARB_N) begin : g_nreq_chk
        $error("rr_arbiter_4: N_REQ must be 4");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_to_chk
        $error("rr_arbiter_4: TIMEOUT_CYCLES must be in 2..255");
    end

    arb_state_t state;
    logic [1:0] ptr;
    req_vec_t   pick;
    logic [1:0] idx;
    logic       rel;
    logic       revoke;

    rr_pick4 u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .idx  (idx)
    );

    // Owner is finished when it says so or stops asking.
    assign rel = done | ~|(req & gnt);

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt;

    // Count cycles spent in GRANT; held at zero while idle so it is clear on entry.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) cnt <= 8'd0;
        else                      cnt <= cnt + 8'd1;
    end

    // A normal release in the same cycle wins over the timeout.
    assign revoke = (state == GRANT) & ~rel & (cnt == 8'(TIMEOUT_CYCLES - 1));

    // Error pulse lines up with the cycle in which gnt first reads zero.
    always_ff @(posedge clk) begin
        if (rst) timeout_err <= 1'b0;
        else     timeout_err <= revoke;
    end
`else
    assign revoke      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Two-state grant FSM; pointer advances past each winner at grant time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state     <= GRANT;
                        gnt       <= pick;
                        gnt_valid <= 1'b1;
                        ptr       <= idx + 2'd1;
                    end
                end
                GRANT: begin
                    if (rel || revoke) begin
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a behavioural model.
module tb_rr_arbiter_4;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic       timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: owner index (-1 when no grant), priority pointer, grant age.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_age   = 0;
    bit m_terr  = 1'b0;

    rr_arbiter_4 #(.N_REQ(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .gnt         (gnt),
        .gnt_valid   (gnt_valid),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] m_gnt();
        return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    endfunction

    // Reference behaviour evaluated from the rules on each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_age = 0; m_terr = 1'b0;
        end else if (m_owner < 0) begin
            m_terr = 1'b0;
            for (int i = 0; i < 4; i++) begin
                int k;
                k = (m_ptr + i) % 4;
                if (req[k] && m_owner < 0) begin
                    m_owner = k;
                    m_ptr   = (k + 1) % 4;
                    m_age   = 0;
                end
            end
        end else begin
            m_terr = 1'b0;
            if (done || !req[m_owner]) begin
                m_owner = -1;
            end else begin
`ifdef ARB_TIMEOUT_EN
                if (m_age == TO - 1) begin
                    m_owner = -1;
                    m_terr  = 1'b1;
                end else begin
                    m_age++;
                end
`endif
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("gnt", 32'(gnt), 32'(m_gnt()));
        chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        chk("onehot0", 32'($onehot0(gnt)), 32'd1);
    end

    // Release current grant with done, then check the next literal grant.
    task automatic release_then(input logic [3:0] exp, input string name);
        done = 1'b1;
        @(negedge clk);
        chk({name, "_gap"}, 32'(gnt), 32'd0);
        done = 1'b0;
        @(negedge clk);
        chk(name, 32'(gnt), 32'(exp));
    endtask

    initial begin
        logic [3:0] rot_seq [4];
        rot_seq[0] = 4'b0010; rot_seq[1] = 4'b0100;
        rot_seq[2] = 4'b1000; rot_seq[3] = 4'b0001;

        rst = 1'b1; req = 4'b1111; done = 1'b0;

        // Reset with all requests pending.
        repeat (2) begin
            @(negedge clk);
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_valid", 32'(gnt_valid), 32'd0);
            chk("rst_terr", 32'(timeout_err), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("first_grant", 32'(gnt), 32'b0001);

        // Rotation through all four with req held.
        for (int i = 0; i < 4; i++) release_then(rot_seq[i], "rotate");

        // Wrap: grant index 3, then req=1001 gives 0, then 3.
        req = 4'b1000;
        release_then(4'b1000, "grant3");
        req = 4'b1001;
        release_then(4'b0001, "wrap0");
        release_then(4'b1000, "wrap3");

        // Owner abandons mid-grant.
        req = 4'b0000;
        @(negedge clk);
        chk("abandon", 32'(gnt), 32'd0);
        req = 4'b0001;
        @(negedge clk);
        chk("grant0", 32'(gnt), 32'b0001);

        // done together with a new req[2].
        req = 4'b0101; done = 1'b1;
        @(negedge clk);
        chk("sim_gap", 32'(gnt), 32'd0);
        done = 1'b0;
        @(negedge clk);
        chk("sim_grant2", 32'(gnt), 32'b0100);

        // Reset in the middle of a grant.
        rst = 1'b1; req = 4'b1111;
        @(negedge clk);
        chk("midrst", 32'(gnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst", 32'(gnt), 32'b0001);

        // Long grant on index 1 with no done.
        req = 4'b0010;
        release_then(4'b0010, "grant1");
`ifdef ARB_TIMEOUT_EN
        repeat (TO - 1) begin
            @(negedge clk);
            chk("to_hold", 32'(gnt), 32'b0010);
        end
        @(negedge clk);
        chk("to_drop", 32'(gnt), 32'd0);
        chk("to_err", 32'(timeout_err), 32'd1);
        req = 4'b1111;
        @(negedge clk);
        chk("to_err_clr", 32'(timeout_err), 32'd0);
        chk("to_skip", 32'(gnt), 32'b0100);
`else
        repeat (40) begin
            @(negedge clk);
            chk("unbounded", 32'(gnt), 32'b0010);
            chk("no_terr", 32'(timeout_err), 32'd0);
        end
`endif
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;

        // Random traffic; the model compare covers every cycle.
        for (int c = 0; c < 3000; c++) begin
            req  = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        rst = 1'b0; req = 4'b0000; done = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
